// File: rtl/pipe_stage_skid_reg.sv
// Pipeline inter-stage register with valid/ready handshake and a two-entry skid buffer.
// The upstream ready is registered, control is masked to a bubble when invalid, and stall cycles are counted.
//
// state    | meaning
// ---------+---------------------------------------------
// ST_EMPTY | no word held; out_valid=0, in_ready=1
// ST_ONE   | main slot full; out_valid=1, in_ready=1
// ST_TWO   | main and skid full; out_valid=1, in_ready=0
module pipe_stage_skid_reg #(
  parameter int              DW          = 16,
  parameter int              CW          = 8,
  parameter logic [CW-1:0]   CTRL_BUBBLE = {CW{1'b0}},
  parameter int              SCW         = 16
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           in_valid,
  output logic           in_ready,
  input  logic [DW-1:0]  in_data,
  input  logic [CW-1:0]  in_ctrl,
  input  logic           flush,
  output logic           out_valid,
  input  logic           out_ready,
  output logic [DW-1:0]  out_data,
  output logic [CW-1:0]  out_ctrl,
  input  logic           clr_stats,
  output logic [SCW-1:0] stall_cnt
);

  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_ONE   = 2'd1,
    ST_TWO   = 2'd2
  } state_t;

  state_t         state_q, state_d;
  logic [DW-1:0]  main_data_q, main_data_d;
  logic [CW-1:0]  main_ctrl_q, main_ctrl_d;
  logic [DW-1:0]  skid_data_q, skid_data_d;
  logic [CW-1:0]  skid_ctrl_q, skid_ctrl_d;
  logic [SCW-1:0] stall_cnt_q, stall_cnt_d;
  logic           accept;
  logic           drain;

  // Handshake outputs depend on registered state only.
  assign in_ready  = (state_q != ST_TWO);
  assign out_valid = (state_q != ST_EMPTY);
  assign out_data  = main_data_q;
  assign out_ctrl  = out_valid ? main_ctrl_q : CTRL_BUBBLE;
  assign stall_cnt = stall_cnt_q;

  assign accept = in_valid & in_ready;
  assign drain  = out_valid & out_ready;

  always_comb begin
    state_d     = state_q;
    main_data_d = main_data_q;
    main_ctrl_d = main_ctrl_q;
    skid_data_d = skid_data_q;
    skid_ctrl_d = skid_ctrl_q;

    if (flush) begin
      // Data is left in place; only control is scrubbed so no stale write enable survives.
      state_d     = ST_EMPTY;
      main_ctrl_d = CTRL_BUBBLE;
      skid_ctrl_d = CTRL_BUBBLE;
    end else begin
      case (state_q)
        ST_EMPTY: begin
          if (accept) begin
            state_d     = ST_ONE;
            main_data_d = in_data;
            main_ctrl_d = in_ctrl;
          end
        end
        ST_ONE: begin
          if (accept && drain) begin
            main_data_d = in_data;
            main_ctrl_d = in_ctrl;
          end else if (accept) begin
            state_d     = ST_TWO;
            skid_data_d = in_data;
            skid_ctrl_d = in_ctrl;
          end else if (drain) begin
            state_d = ST_EMPTY;
          end
        end
        ST_TWO: begin
          if (drain) begin
            state_d     = ST_ONE;
            main_data_d = skid_data_q;
            main_ctrl_d = skid_ctrl_q;
          end
        end
        default: state_d = ST_EMPTY;
      endcase
    end
  end

  always_comb begin
    stall_cnt_d = stall_cnt_q;
    if (clr_stats)
      stall_cnt_d = '0;
    else if (out_valid && !out_ready && (stall_cnt_q != {SCW{1'b1}}))
      stall_cnt_d = stall_cnt_q + {{(SCW-1){1'b0}}, 1'b1};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_EMPTY;
      main_data_q <= '0;
      main_ctrl_q <= CTRL_BUBBLE;
      skid_data_q <= '0;
      skid_ctrl_q <= CTRL_BUBBLE;
      stall_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      main_data_q <= main_data_d;
      main_ctrl_q <= main_ctrl_d;
      skid_data_q <= skid_data_d;
      skid_ctrl_q <= skid_ctrl_d;
      stall_cnt_q <= stall_cnt_d;
    end
  end

endmodule

// File: tb/tb_pipe_stage_skid_reg.sv
// Self-checking bench for pipe_stage_skid_reg: constant vector table, directed corner cases,
// and random traffic checked against a queue-based model of the stage.
module tb_pipe_stage_skid_reg;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid, flush, out_ready, clr_stats;
  logic [15:0] in_data;
  logic [7:0]  in_ctrl;
  logic        in_ready, out_valid;
  logic [15:0] out_data;
  logic [7:0]  out_ctrl;
  logic [15:0] stall_cnt;
  logic        in_ready_s, out_valid_s;
  logic [15:0] out_data_s;
  logic [7:0]  out_ctrl_s;
  logic [3:0]  stall_cnt_s;

  always #5 clk = ~clk;

  pipe_stage_skid_reg dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .in_data(in_data), .in_ctrl(in_ctrl), .flush(flush), .out_valid(out_valid),
    .out_ready(out_ready), .out_data(out_data), .out_ctrl(out_ctrl),
    .clr_stats(clr_stats), .stall_cnt(stall_cnt)
  );

  pipe_stage_skid_reg #(.SCW(4)) dut_s (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready_s),
    .in_data(in_data), .in_ctrl(in_ctrl), .flush(flush), .out_valid(out_valid_s),
    .out_ready(out_ready), .out_data(out_data_s), .out_ctrl(out_ctrl_s),
    .clr_stats(clr_stats), .stall_cnt(stall_cnt_s)
  );

  // Reference model: a FIFO of held words plus the data last seen at the head.
  typedef struct packed {
    logic [15:0] d;
    logic [7:0]  c;
  } word_t;

  word_t       mq[$];
  logic [15:0] m_last;
  int          m_stall, m_stall_s;
  int          tests, fails;

  typedef struct {
    bit          iv;
    logic [15:0] d;
    logic [7:0]  c;
    bit          fl;
    bit          ordy;
    bit          clr;
    bit          ev;
    bit          er;
    logic [15:0] ed;
    logic [7:0]  ec;
    int          es;
  } vec_t;

  vec_t tbl[13];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s @%0t: got %0h expected %0h", nm, $time, act, exp);
    end
  endtask

  task automatic model_reset();
    mq.delete();
    m_last    = '0;
    m_stall   = 0;
    m_stall_s = 0;
  endtask

  task automatic model_clock();
    bit acc, drn;
    acc = in_valid && (mq.size() < 2);
    drn = (mq.size() > 0) && out_ready;
    if (clr_stats) begin
      m_stall   = 0;
      m_stall_s = 0;
    end else if (mq.size() > 0 && !out_ready) begin
      if (m_stall < 65535) m_stall++;
      if (m_stall_s < 15) m_stall_s++;
    end
    if (drn) void'(mq.pop_front());
    if (flush) mq.delete();
    else if (acc) mq.push_back('{d: in_data, c: in_ctrl});
    if (mq.size() > 0) m_last = mq[0].d;
  endtask

  task automatic check_model();
    chk("out_valid", {31'd0, out_valid}, {31'd0, mq.size() > 0});
    chk("in_ready", {31'd0, in_ready}, {31'd0, mq.size() < 2});
    chk("out_data", {16'd0, out_data}, {16'd0, m_last});
    chk("out_ctrl", {24'd0, out_ctrl}, (mq.size() > 0) ? {24'd0, mq[0].c} : 32'd0);
    chk("stall_cnt", {16'd0, stall_cnt}, m_stall);
    chk("stall_cnt_s4", {28'd0, stall_cnt_s}, m_stall_s);
  endtask

  task automatic step();
    @(posedge clk);
    model_clock();
    #1;
    check_model();
  endtask

  task automatic drive(input bit iv, input logic [15:0] d, input logic [7:0] c,
                       input bit fl, input bit ordy, input bit clr);
    in_valid  = iv;
    in_data   = d;
    in_ctrl   = c;
    flush     = fl;
    out_ready = ordy;
    clr_stats = clr;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    drive(0, 16'h0, 8'h0, 0, 0, 0);
    model_reset();
    #12;
    check_model();
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    tests = 0;
    fails = 0;

    //            iv  d        c      fl ordy clr  ev er ed       ec     es
    tbl[0]  = '{1, 16'h1234, 8'hA5, 0, 1, 0,   1, 1, 16'h1234, 8'hA5, 0};
    tbl[1]  = '{0, 16'h0000, 8'h00, 0, 1, 0,   0, 1, 16'h1234, 8'h00, 0};
    tbl[2]  = '{1, 16'hAAAA, 8'h11, 0, 0, 0,   1, 1, 16'hAAAA, 8'h11, 0};
    tbl[3]  = '{1, 16'hBBBB, 8'h22, 0, 0, 0,   1, 0, 16'hAAAA, 8'h11, 1};
    tbl[4]  = '{1, 16'hCCCC, 8'h33, 0, 0, 0,   1, 0, 16'hAAAA, 8'h11, 2};
    tbl[5]  = '{1, 16'hCCCC, 8'h33, 0, 1, 0,   1, 1, 16'hBBBB, 8'h22, 2};
    tbl[6]  = '{1, 16'hCCCC, 8'h33, 0, 1, 0,   1, 1, 16'hCCCC, 8'h33, 2};
    tbl[7]  = '{0, 16'h0000, 8'h00, 0, 1, 0,   0, 1, 16'hCCCC, 8'h00, 2};
    tbl[8]  = '{1, 16'h1111, 8'hFF, 0, 0, 0,   1, 1, 16'h1111, 8'hFF, 2};
    tbl[9]  = '{1, 16'h2222, 8'hFF, 0, 0, 0,   1, 0, 16'h1111, 8'hFF, 3};
    tbl[10] = '{1, 16'h3333, 8'hFF, 1, 0, 0,   0, 1, 16'h1111, 8'h00, 4};
    tbl[11] = '{0, 16'h0000, 8'h00, 0, 1, 0,   0, 1, 16'h1111, 8'h00, 4};
    tbl[12] = '{0, 16'h0000, 8'h00, 0, 1, 1,   0, 1, 16'h1111, 8'h00, 0};

    do_reset();
    chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
    chk("rst_in_ready", {31'd0, in_ready}, 32'd1);
    chk("rst_out_data", {16'd0, out_data}, 32'd0);

    for (int i = 0; i < 13; i++) begin
      drive(tbl[i].iv, tbl[i].d, tbl[i].c, tbl[i].fl, tbl[i].ordy, tbl[i].clr);
      step();
      chk($sformatf("vec%0d_valid", i), {31'd0, out_valid}, {31'd0, tbl[i].ev});
      chk($sformatf("vec%0d_ready", i), {31'd0, in_ready}, {31'd0, tbl[i].er});
      chk($sformatf("vec%0d_data", i), {16'd0, out_data}, {16'd0, tbl[i].ed});
      chk($sformatf("vec%0d_ctrl", i), {24'd0, out_ctrl}, {24'd0, tbl[i].ec});
      chk($sformatf("vec%0d_stall", i), {16'd0, stall_cnt}, tbl[i].es);
    end

    // Back-to-back stream with downstream always ready: no bubbles, no stalls.
    for (int i = 1; i <= 16; i++) begin
      drive(1, i[15:0], 8'h5A, 0, 1, 0);
      step();
      chk("stream_valid", {31'd0, out_valid}, 32'd1);
      chk("stream_data", {16'd0, out_data}, i);
    end
    drive(0, 16'h0, 8'h0, 0, 1, 0);
    step();
    chk("stream_stall", {16'd0, stall_cnt}, 32'd0);

    // Saturation of the 4-bit counter, then clear.
    drive(1, 16'h7777, 8'h44, 0, 0, 0);
    step();
    drive(0, 16'h0, 8'h0, 0, 0, 0);
    for (int i = 0; i < 20; i++) step();
    chk("sat_stall_s4", {28'd0, stall_cnt_s}, 32'hF);
    chk("sat_stall_16", {16'd0, stall_cnt}, 32'd20);
    drive(0, 16'h0, 8'h0, 0, 0, 1);
    step();
    chk("clr_stall_s4", {28'd0, stall_cnt_s}, 32'd0);
    drive(0, 16'h0, 8'h0, 0, 1, 0);
    step();

    // Asynchronous reset between edges while holding one word.
    drive(1, 16'h9999, 8'hC3, 0, 0, 0);
    step();
    drive(0, 16'h0, 8'h0, 0, 0, 0);
    #2;
    rst_n = 1'b0;
    #1;
    chk("async_rst_valid", {31'd0, out_valid}, 32'd0);
    chk("async_rst_ctrl", {24'd0, out_ctrl}, 32'd0);
    chk("async_rst_ready", {31'd0, in_ready}, 32'd1);
    do_reset();
    step();

    // Random traffic against the model.
    for (int n = 0; n < 500; n++) begin
      drive($urandom_range(0, 3) != 0, 16'($urandom), 8'($urandom),
            $urandom_range(0, 19) == 0, $urandom_range(0, 2) != 0,
            $urandom_range(0, 39) == 0);
      step();
    end
    drive(0, 16'h0, 8'h0, 0, 1, 0);
    step();
    step();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
